// File: rtl/mips_pkg.sv
// Shared MIPS datapath types: write-back FSM states and named source indices.
package mips_pkg;

    localparam int DATA_W  = 32;

    localparam int SRC_ULA = 0;
    localparam int SRC_MEM = 1;
    localparam int SRC_IN  = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_IN = 2'd1,
        WRITE   = 2'd2
    } wb_state_e;

    function automatic logic sel_in_range(
        input logic [31:0] sel,
        input int          n_src
    );
        return sel < 32'(n_src);
    endfunction

endpackage

// File: rtl/strobe_edge_detect.sv
// Button strobe rising-edge detector; MULTIPLEX_ESCRITA_SYNC_EN adds a
// two-flop synchronizer in front of the edge detection.
module strobe_edge_detect (
    input  logic clock,
    input  logic reset,
    input  logic strobe_i,
    output logic rise_o
);

    logic level;
    logic hist_q;
    logic hist_d;

`ifdef MULTIPLEX_ESCRITA_SYNC_EN
    logic [1:0] sync_q;
    logic [1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[0], strobe_i};
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign level = sync_q[1];
`else
    assign level = strobe_i;
`endif

    // History follows the level every cycle, so a held-high strobe never
    // produces a second pulse.
    always_comb begin
        hist_d = level;
        rise_o = level & ~hist_q;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            hist_q <= 1'b0;
        end else begin
            hist_q <= hist_d;
        end
    end

endmodule

// File: rtl/multiplex_escrita_seq.sv
// Registered register-file write-back selector with external-input stall.
// Optional strobe synchronizer: MULTIPLEX_ESCRITA_SYNC_EN.
module multiplex_escrita_seq #(
    parameter  int DATA_W = mips_pkg::DATA_W,
    parameter  int N_SRC  = 4,
    parameter  int IN_IDX = mips_pkg::SRC_IN,
    localparam int SEL_W  = $clog2(N_SRC)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [N_SRC*DATA_W-1:0] src_data,
    input  logic [SEL_W-1:0]        mux_ESCRITA,
    input  logic                    wb_req,
    input  logic                    in_strobe,
    output logic [DATA_W-1:0]       dado_escrita,
    output logic                    wr_en,
    output logic                    stall,
    output logic                    sel_err
);

    import mips_pkg::*;

    wb_state_e         state_q;
    wb_state_e         state_d;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;
    logic              wr_en_q;
    logic              wr_en_d;
    logic              sel_err_q;
    logic              sel_err_d;

    logic              strobe_rise;
    logic [31:0]       sel_ext;
    logic              sel_ok;
    logic              sel_is_in;
    logic [DATA_W-1:0] picked;
    logic [DATA_W-1:0] in_word;

    strobe_edge_detect u_strobe (
        .clock    (clock),
        .reset    (reset),
        .strobe_i (in_strobe),
        .rise_o   (strobe_rise)
    );

    // Loop mux: an out-of-range select simply matches nothing.
    always_comb begin
        picked = '0;
        for (int k = 0; k < N_SRC; k++) begin
            if (sel_ext == 32'(k)) begin
                picked = src_data[k*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        sel_ext   = 32'(mux_ESCRITA);
        sel_ok    = sel_in_range(sel_ext, N_SRC);
        sel_is_in = sel_ok && (sel_ext == 32'(IN_IDX));
        in_word   = src_data[IN_IDX*DATA_W +: DATA_W];
    end

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        wr_en_d   = 1'b0;
        sel_err_d = sel_err_q;
        stall     = 1'b0;
        unique case (state_q)
            WAIT_IN: begin
                stall = 1'b1;
                if (strobe_rise) begin
                    data_d  = in_word;
                    wr_en_d = 1'b1;
                    state_d = WRITE;
                end
            end
            IDLE, WRITE: begin
                state_d = IDLE;
                if (wb_req) begin
                    if (!sel_ok) begin
                        sel_err_d = 1'b1;
                    end else if (sel_is_in) begin
                        stall   = 1'b1;
                        state_d = WAIT_IN;
                    end else begin
                        data_d  = picked;
                        wr_en_d = 1'b1;
                        state_d = WRITE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= IDLE;
            data_q    <= '0;
            wr_en_q   <= 1'b0;
            sel_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            wr_en_q   <= wr_en_d;
            sel_err_q <= sel_err_d;
        end
    end

    assign dado_escrita = data_q;
    assign wr_en        = wr_en_q;
    assign sel_err      = sel_err_q;

endmodule
